// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - shared memory port between controller and memory
interface multicycle_controller_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   // controller side: issues requests, sees completion
   modport master (
      output mem_req,
      output mem_we,
      output iord,
      input  mem_ready
   );

   // memory side: accepts requests, signals completion
   modport slave (
      input  mem_req,
      input  mem_we,
      input  iord,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle control FSM sharing one memory port
module multicycle_controller #(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         instr,
   input  logic                     zero,
   multicycle_controller_if.master  mem,
   output logic                     irwrite,
   output logic                     pcwrite,
   output logic                     regwrite,
   output logic                     regdst,
   output logic                     memtoreg,
   output logic                     alusrca,
   output logic [1:0]               alusrcb,
   output logic [1:0]               pcsrc,
   output logic [3:0]               alucontrol,
   output logic                     illegal,
   output logic                     halted
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_REXEC  = 4'd3;
   localparam logic [3:0] S_RWB    = 4'd4;
   localparam logic [3:0] S_IEXEC  = 4'd5;
   localparam logic [3:0] S_IWB    = 4'd6;
   localparam logic [3:0] S_MEMADR = 4'd7;
   localparam logic [3:0] S_MEMRD  = 4'd8;
   localparam logic [3:0] S_MEMWB  = 4'd9;
   localparam logic [3:0] S_MEMWR  = 4'd10;
   localparam logic [3:0] S_BRANCH = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;
   localparam logic [3:0] S_HALT   = 4'd13;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_J     = 4'b0001;
   localparam logic [3:0] OP_ADDI  = 4'b0010;
   localparam logic [3:0] OP_LW    = 4'b0011;
   localparam logic [3:0] OP_SW    = 4'b0100;
   localparam logic [3:0] OP_BEQ   = 4'b0101;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0001;
   localparam logic [3:0] FN_AND = 4'b0010;
   localparam logic [3:0] FN_OR  = 4'b0011;
   localparam logic [3:0] FN_SLT = 4'b0100;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_TWO  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   logic [3:0] state_q;
   logic [3:0] state_d;

   logic [3:0] opcode;
   logic [3:0] funct;
   logic       opcode_ok;
   logic       funct_ok;
   logic [3:0] funct_alu;
   logic       unused_instr_bits;

   assign opcode = instr[WIDTH-1 -: 4];
   assign funct  = instr[3:0];
   // Middle instruction bits (register fields, immediates) belong to the datapath.
   assign unused_instr_bits = ^instr[WIDTH-5:4];

   // opcode legality check used in DECODE
   always_comb begin
      opcode_ok = 1'b0;
      case (opcode)
         OP_RTYPE, OP_J, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: opcode_ok = 1'b1;
         default: opcode_ok = 1'b0;
      endcase
   end

   // R-type funct to ALU operation, flagging undefined functs
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: begin
            funct_ok  = 1'b0;
            funct_alu = ALU_AND;
         end
      endcase
   end

   // next-state logic; memory states hold until the transfer completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      state_d = S_REXEC;
               OP_ADDI:       state_d = S_IEXEC;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_HALT:       state_d = S_HALT;
               default:       state_d = S_FETCH;
            endcase
         end
         S_REXEC:  state_d = funct_ok ? S_RWB : S_FETCH;
         S_RWB:    state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem.mem_ready ? S_FETCH : S_MEMWR;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // state register; reset abandons any pending memory request
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // output decode: Moore per state, except the fetch enables and branch pcwrite
   always_comb begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.iord    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = SRCB_REG;
      pcsrc       = PC_ALU;
      alucontrol  = ALU_AND;
      illegal     = 1'b0;
      halted      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem.mem_req = 1'b1;
            alusrcb     = SRCB_TWO;
            alucontrol  = ALU_ADD;
            pcsrc       = PC_ALU;
            irwrite     = mem.mem_ready;
            pcwrite     = mem.mem_ready;
         end
         S_DECODE: begin
            alusrcb    = SRCB_IMM2;
            alucontrol = ALU_ADD;
            illegal    = ~opcode_ok;
         end
         S_REXEC: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_REG;
            alucontrol = funct_alu;
            illegal    = ~funct_ok;
         end
         S_RWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_IEXEC, S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            alucontrol = ALU_ADD;
         end
         S_IWB: begin
            regwrite = 1'b1;
         end
         S_MEMRD: begin
            mem.mem_req = 1'b1;
            mem.iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
            mem.iord    = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_REG;
            alucontrol = ALU_SUB;
            pcsrc      = PC_ALUOUT;
            pcwrite    = zero;
         end
         S_JUMP: begin
            pcsrc   = PC_JUMP;
            pcwrite = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic [15:0] instr;
   logic        zero;
   logic        irwrite, pcwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0]  alusrcb, pcsrc;
   logic [3:0]  alucontrol;
   logic        illegal, halted;

   multicycle_controller_if mem_if ();

   multicycle_controller #(.WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem        (mem_if.master),
      .irwrite    (irwrite),
      .pcwrite    (pcwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .illegal    (illegal),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {mem_req, mem_we, iord, irwrite, pcwrite, regwrite, regdst, memtoreg,
   //  alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[3:0], illegal, halted}
   localparam logic [18:0] O_IDLE    = '0;
   localparam logic [18:0] O_FETCH_W = {1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b01, 2'b00, 4'b0010, 1'b0,1'b0};
   localparam logic [18:0] O_FETCH_R = {1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0, 2'b01, 2'b00, 4'b0010, 1'b0,1'b0};
   localparam logic [18:0] O_DECODE  = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b11, 2'b00, 4'b0010, 1'b0,1'b0};
   localparam logic [18:0] O_DEC_ILL = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b11, 2'b00, 4'b0010, 1'b1,1'b0};
   localparam logic [18:0] O_REX_ADD = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b00, 2'b00, 4'b0010, 1'b0,1'b0};
   localparam logic [18:0] O_REX_SLT = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b00, 2'b00, 4'b0111, 1'b0,1'b0};
   localparam logic [18:0] O_REX_ILL = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b1,1'b0};
   localparam logic [18:0] O_RWB     = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_IEXEC   = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b10, 2'b00, 4'b0010, 1'b0,1'b0};
   localparam logic [18:0] O_IWB     = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_MEMRD   = {1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_MEMWB   = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_MEMWR   = {1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_BR_Z1   = {1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, 2'b00, 2'b01, 4'b0110, 1'b0,1'b0};
   localparam logic [18:0] O_BR_Z0   = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b00, 2'b01, 4'b0110, 1'b0,1'b0};
   localparam logic [18:0] O_JUMP    = {1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 1'b0,1'b0};
   localparam logic [18:0] O_HALT    = {1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0,1'b1};

   localparam logic [18:0] M_ALL    = '1;
   localparam logic [18:0] M_NO_ALU = ~19'b0000000000000111100;

   typedef struct {
      logic [18:0] exp;
      logic [18:0] msk;
      string       tag;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        n_vec;
   int        n_bad;

   function automatic logic [18:0] observed();
      return {mem_if.mem_req, mem_if.mem_we, mem_if.iord, irwrite, pcwrite, regwrite,
              regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal, halted};
   endfunction

   // one clock cycle: drive inputs after the falling edge, queue the expected
   // outputs for this cycle, then compare once combinational outputs settle
   task automatic cyc(input logic rst, input logic rdy, input logic z,
                      input logic [15:0] ins, input logic [18:0] exp,
                      input logic [18:0] msk, input string tag);
      sb_entry_t e;
      sb_entry_t w;
      logic [18:0] got;
      @(negedge clk);
      reset            = rst;
      mem_if.mem_ready = rdy;
      zero             = z;
      instr            = ins;
      e.exp = exp;
      e.msk = msk;
      e.tag = tag;
      sb_q.push_back(e);
      #1;
      w   = sb_q.pop_front();
      got = observed() & w.msk;
      n_vec++;
      assert (got === (w.exp & w.msk))
      else begin
         n_bad++;
         $error("FAIL %s: observed %05h expected %05h", w.tag, got, w.exp & w.msk);
      end
   endtask

   initial begin
      n_vec            = 0;
      n_bad            = 0;
      reset            = 1'b0;
      zero             = 1'b0;
      instr            = 16'h0000;
      mem_if.mem_ready = 1'b0;

      // reset, then ADD with zero-wait memory
      cyc(1'b0, 1'b1, 1'b0, 16'h0120, O_IDLE,    M_ALL, "reset_idle0");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_IDLE,    M_ALL, "reset_idle1");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_FETCH_R, M_ALL, "add_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_DECODE,  M_ALL, "add_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_REX_ADD, M_ALL, "add_rexec");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_RWB,     M_ALL, "add_rwb");

      // LW with two wait cycles in MEMRD
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_FETCH_R, M_ALL, "lw_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_DECODE,  M_ALL, "lw_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_IEXEC,   M_ALL, "lw_memadr");
      cyc(1'b1, 1'b0, 1'b0, 16'h3124, O_MEMRD,   M_ALL, "lw_memrd_w1");
      cyc(1'b1, 1'b0, 1'b0, 16'h3124, O_MEMRD,   M_ALL, "lw_memrd_w2");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_MEMRD,   M_ALL, "lw_memrd_done");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_MEMWB,   M_ALL, "lw_memwb");

      // fetch stalled for a cycle, then BEQ taken
      cyc(1'b1, 1'b0, 1'b1, 16'h5123, O_FETCH_W, M_ALL, "beq1_fetch_wait");
      cyc(1'b1, 1'b1, 1'b1, 16'h5123, O_FETCH_R, M_ALL, "beq1_fetch");
      cyc(1'b1, 1'b1, 1'b1, 16'h5123, O_DECODE,  M_ALL, "beq1_decode");
      cyc(1'b1, 1'b1, 1'b1, 16'h5123, O_BR_Z1,   M_ALL, "beq1_branch");

      // BEQ not taken
      cyc(1'b1, 1'b1, 1'b0, 16'h5123, O_FETCH_R, M_ALL, "beq0_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h5123, O_DECODE,  M_ALL, "beq0_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h5123, O_BR_Z0,   M_ALL, "beq0_branch");

      // J
      cyc(1'b1, 1'b1, 1'b0, 16'h1000, O_FETCH_R, M_ALL, "j_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h1000, O_DECODE,  M_ALL, "j_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h1000, O_JUMP,    M_ALL, "j_jump");

      // illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
      cyc(1'b1, 1'b1, 1'b0, 16'h7000, O_FETCH_R, M_ALL, "ill_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h7000, O_DEC_ILL, M_ALL, "ill_decode");

      // ADDI
      cyc(1'b1, 1'b1, 1'b0, 16'h2124, O_FETCH_R, M_ALL, "addi_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h2124, O_DECODE,  M_ALL, "addi_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h2124, O_IEXEC,   M_ALL, "addi_iexec");
      cyc(1'b1, 1'b1, 1'b0, 16'h2124, O_IWB,     M_ALL, "addi_iwb");

      // SLT R-type
      cyc(1'b1, 1'b1, 1'b0, 16'h0124, O_FETCH_R, M_ALL, "slt_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h0124, O_DECODE,  M_ALL, "slt_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h0124, O_REX_SLT, M_ALL, "slt_rexec");
      cyc(1'b1, 1'b1, 1'b0, 16'h0124, O_RWB,     M_ALL, "slt_rwb");

      // illegal funct: flagged in REXEC, no write-back
      cyc(1'b1, 1'b1, 1'b0, 16'h0125, O_FETCH_R, M_ALL,    "badfn_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h0125, O_DECODE,  M_ALL,    "badfn_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h0125, O_REX_ILL, M_NO_ALU, "badfn_rexec");

      // SW with zero-wait memory
      cyc(1'b1, 1'b1, 1'b0, 16'h4124, O_FETCH_R, M_ALL, "sw_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h4124, O_DECODE,  M_ALL, "sw_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h4124, O_IEXEC,   M_ALL, "sw_memadr");
      cyc(1'b1, 1'b1, 1'b0, 16'h4124, O_MEMWR,   M_ALL, "sw_memwr");

      // HALT holds with only halted set, whatever mem_ready/zero do
      cyc(1'b1, 1'b1, 1'b0, 16'hF000, O_FETCH_R, M_ALL, "halt_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'hF000, O_DECODE,  M_ALL, "halt_decode");
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, i[0], i[1], 16'hF000, O_HALT, M_ALL, "halt_hold");
      end

      // reset out of HALT
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, O_HALT,    M_ALL, "halt_rst_edge");
      cyc(1'b1, 1'b0, 1'b0, 16'h3124, O_IDLE,    M_ALL, "halt_rst_idle");

      // reset during a MEMRD wait abandons the request
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_FETCH_R, M_ALL, "lw2_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_DECODE,  M_ALL, "lw2_decode");
      cyc(1'b1, 1'b1, 1'b0, 16'h3124, O_IEXEC,   M_ALL, "lw2_memadr");
      cyc(1'b1, 1'b0, 1'b0, 16'h3124, O_MEMRD,   M_ALL, "lw2_memrd_wait");
      cyc(1'b0, 1'b0, 1'b0, 16'h3124, O_MEMRD,   M_ALL, "lw2_rst_edge");
      cyc(1'b1, 1'b0, 1'b0, 16'h3124, O_IDLE,    M_ALL, "lw2_rst_idle");
      cyc(1'b1, 1'b0, 1'b0, 16'h0120, O_FETCH_W, M_ALL, "post_rst_fetch_w");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_FETCH_R, M_ALL, "post_rst_fetch");
      cyc(1'b1, 1'b1, 1'b0, 16'h0120, O_DECODE,  M_ALL, "post_rst_decode");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
